// File: rtl/wb_mon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wb_mon_pkg                                             |
// | Purpose : fault-bit indices, fault vector width, monitor states  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package wb_mon_pkg;

  localparam int FAULT_W = 8;

  localparam int c_bit_stb_no_cyc   = 0;
  localparam int c_bit_stall_change = 1;
  localparam int c_bit_resp_no_cyc  = 2;
  localparam int c_bit_ack_and_err  = 3;
  localparam int c_bit_count        = 4;
  localparam int c_bit_stall_limit  = 5;
  localparam int c_bit_ack_timeout  = 6;
  localparam int c_bit_cyc_hold     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ABORT = 2'd3
  } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_mon_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wb_mon_timer                                           |
// | Purpose : saturating run-length counter; flags LIMIT consecutive |
// |           active cycles. LIMIT = 0 disables it.                  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module wb_mon_timer #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_active,
  output logic o_expired
);

  generate
    if (LIMIT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused  = &{1'b0, i_clk, i_reset_n, i_active};
      assign o_expired = 1'b0;
    end else begin : g_count
      localparam int c_cw = $clog2(LIMIT + 1);

      logic [c_cw-1:0] r_count;
      logic [c_cw-1:0] w_count_next;

      // Holds at LIMIT so the flag stays asserted for as long as the run lasts.
      always_comb begin
        w_count_next = r_count;
        if (!i_active) begin
          w_count_next = '0;
        end else if (r_count != c_cw'(LIMIT)) begin
          w_count_next = r_count + 1'b1;
        end
      end

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_count <= '0;
        end else begin
          r_count <= w_count_next;
        end
      end

      assign o_expired = i_active && (w_count_next == c_cw'(LIMIT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_protocol_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : wb_protocol_monitor                                    |
// | Purpose : passive pipelined-Wishbone rule checker, sticky faults.|
// |           Define WBMON_CAPTURE_EN for first-fault addr/we capture|
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module wb_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int LGDEPTH       = 4,
  parameter int MAX_STALL     = 4,
  parameter int MAX_ACK_DELAY = 10,
  parameter int OPT_RMW       = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data,
  input  logic [DW/8-1:0]    i_wb_sel,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  input  logic               i_wb_err,
  input  logic               i_clear,
  output logic               o_fault,
  output logic [FAULT_W-1:0] o_fault_vec,
  output logic [LGDEPTH-1:0] o_outstanding,
  output logic [1:0]         o_state,
  output logic [AW-1:0]      o_cap_addr,
  output logic               o_cap_we,
  output logic               o_cap_valid
);

  logic               w_accept;
  logic               w_resp;
  logic [LGDEPTH-1:0] w_reqs_next;
  logic [LGDEPTH-1:0] w_acks_next;
  logic [LGDEPTH-1:0] r_reqs;
  logic [LGDEPTH-1:0] r_acks;
  logic [LGDEPTH-1:0] r_outstanding;

  logic               r_cyc_d;
  logic               r_err_d;
  logic               r_stalled;
  logic               r_prev_we;
  logic [AW-1:0]      r_prev_addr;
  logic [DW-1:0]      r_prev_data;
  logic [DW/8-1:0]    r_prev_sel;

  mon_state_t         r_state;
  mon_state_t         w_state_next;

  logic               w_stall_active;
  logic               w_wait_active;
  logic               w_stall_expired;
  logic               w_wait_expired;
  logic [FAULT_W-1:0] w_fault_now;
  logic [FAULT_W-1:0] r_fault_vec;

  assign w_accept    = i_wb_cyc && i_wb_stb && !i_wb_stall;
  assign w_resp      = i_wb_ack || i_wb_err;
  assign w_reqs_next = i_wb_cyc ? r_reqs + LGDEPTH'(w_accept) : '0;
  assign w_acks_next = i_wb_cyc ? r_acks + LGDEPTH'(w_resp)   : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_reqs        <= '0;
      r_acks        <= '0;
      r_outstanding <= '0;
      r_cyc_d       <= 1'b0;
      r_err_d       <= 1'b0;
      r_stalled     <= 1'b0;
      r_prev_we     <= 1'b0;
      r_prev_addr   <= '0;
      r_prev_data   <= '0;
      r_prev_sel    <= '0;
    end else begin
      r_reqs        <= w_reqs_next;
      r_acks        <= w_acks_next;
      r_outstanding <= w_reqs_next - w_acks_next;
      r_cyc_d       <= i_wb_cyc;
      r_err_d       <= i_wb_err;
      r_stalled     <= i_wb_cyc && i_wb_stb && i_wb_stall;
      r_prev_we     <= i_wb_we;
      r_prev_addr   <= i_wb_addr;
      r_prev_data   <= i_wb_data;
      r_prev_sel    <= i_wb_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A bus with CYC held after an abort is not re-entered until CYC rises again.
  always_comb begin
    w_state_next = r_state;
    if (!i_wb_cyc) begin
      w_state_next = ST_IDLE;
    end else if (i_wb_err) begin
      w_state_next = ST_ABORT;
    end else begin
      case (r_state)
        ST_IDLE:  if (!r_cyc_d) w_state_next = ST_BUSY;
        ST_BUSY:  if (!i_wb_stb && (r_outstanding != '0)) w_state_next = ST_WAIT;
        ST_WAIT:  if (i_wb_stb) w_state_next = ST_BUSY;
        ST_ABORT: w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_stall_active = i_wb_stb && i_wb_stall;
  assign w_wait_active  = (r_state == ST_WAIT) && !w_resp;

  wb_mon_timer #(
    .LIMIT (MAX_STALL)
  ) u_stall_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_active  (w_stall_active),
    .o_expired (w_stall_expired)
  );

  wb_mon_timer #(
    .LIMIT (MAX_ACK_DELAY)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_active  (w_wait_active),
    .o_expired (w_wait_expired)
  );

  always_comb begin
    w_fault_now = '0;
    w_fault_now[c_bit_stb_no_cyc]   = i_wb_stb && !i_wb_cyc;
    w_fault_now[c_bit_stall_change] = r_stalled && i_wb_cyc &&
                                      (!i_wb_stb || (i_wb_we != r_prev_we) ||
                                       (i_wb_addr != r_prev_addr) ||
                                       (i_wb_data != r_prev_data) ||
                                       (i_wb_sel != r_prev_sel));
    w_fault_now[c_bit_resp_no_cyc]  = w_resp && !r_cyc_d;
    w_fault_now[c_bit_ack_and_err]  = i_wb_ack && i_wb_err;
    w_fault_now[c_bit_count]        = (i_wb_ack && (r_outstanding == '0)) ||
                                      (w_accept && (r_outstanding == '1));
    w_fault_now[c_bit_stall_limit]  = w_stall_expired;
    w_fault_now[c_bit_ack_timeout]  = w_wait_expired;
    w_fault_now[c_bit_cyc_hold]     = (r_err_d && i_wb_cyc) ||
                                      ((OPT_RMW == 0) && i_wb_cyc && !i_wb_stb &&
                                       (r_outstanding == '0));
  end

  // Clear drops history only; anything detected this cycle still lands.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fault_vec <= '0;
    end else if (i_clear) begin
      r_fault_vec <= w_fault_now;
    end else begin
      r_fault_vec <= r_fault_vec | w_fault_now;
    end
  end

  assign o_fault       = |r_fault_vec;
  assign o_fault_vec   = r_fault_vec;
  assign o_outstanding = r_outstanding;
  assign o_state       = r_state;

`ifdef WBMON_CAPTURE_EN
  logic          w_req_now;
  logic          w_new_fault;
  logic [AW-1:0] r_last_addr;
  logic          r_last_we;
  logic [AW-1:0] r_cap_addr;
  logic          r_cap_we;
  logic          r_cap_valid;

  assign w_req_now   = i_wb_cyc && i_wb_stb;
  assign w_new_fault = |w_fault_now;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_addr <= '0;
      r_last_we   <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_we    <= 1'b0;
      r_cap_valid <= 1'b0;
    end else begin
      if (w_req_now) begin
        r_last_addr <= i_wb_addr;
        r_last_we   <= i_wb_we;
      end
      if (w_new_fault && (!r_cap_valid || i_clear)) begin
        r_cap_addr  <= w_req_now ? i_wb_addr : r_last_addr;
        r_cap_we    <= w_req_now ? i_wb_we   : r_last_we;
        r_cap_valid <= 1'b1;
      end else if (i_clear) begin
        r_cap_addr  <= '0;
        r_cap_we    <= 1'b0;
        r_cap_valid <= 1'b0;
      end
    end
  end

  assign o_cap_addr  = r_cap_addr;
  assign o_cap_we    = r_cap_we;
  assign o_cap_valid = r_cap_valid;
`else
  assign o_cap_addr  = '0;
  assign o_cap_we    = 1'b0;
  assign o_cap_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_protocol_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_wb_protocol_monitor                                 |
// | Purpose : directed scenarios plus random bus traffic vs. a       |
// |           history-based rule model of wb_protocol_monitor        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_wb_protocol_monitor;

  localparam int AW            = 32;
  localparam int DW            = 32;
  localparam int LGDEPTH       = 4;
  localparam int MAX_STALL     = 4;
  localparam int MAX_ACK_DELAY = 10;
  localparam int OPT_RMW       = 0;
  localparam int OMAX          = (1 << LGDEPTH) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               bus_cyc = 1'b0, bus_stb = 1'b0, bus_we = 1'b0;
  logic [AW-1:0]      bus_addr = '0;
  logic [DW-1:0]      bus_data = '0;
  logic [DW/8-1:0]    bus_sel = '0;
  logic               bus_ack = 1'b0, bus_stall = 1'b0, bus_err = 1'b0, bus_clear = 1'b0;
  logic               o_fault;
  logic [7:0]         o_fault_vec;
  logic [LGDEPTH-1:0] o_outstanding;
  logic [1:0]         o_state;
  logic [AW-1:0]      o_cap_addr;
  logic               o_cap_we, o_cap_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_protocol_monitor #(
    .AW(AW), .DW(DW), .LGDEPTH(LGDEPTH), .MAX_STALL(MAX_STALL),
    .MAX_ACK_DELAY(MAX_ACK_DELAY), .OPT_RMW(OPT_RMW)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(bus_cyc), .i_wb_stb(bus_stb), .i_wb_we(bus_we),
    .i_wb_addr(bus_addr), .i_wb_data(bus_data), .i_wb_sel(bus_sel),
    .i_wb_ack(bus_ack), .i_wb_stall(bus_stall), .i_wb_err(bus_err),
    .i_clear(bus_clear),
    .o_fault(o_fault), .o_fault_vec(o_fault_vec), .o_outstanding(o_outstanding),
    .o_state(o_state), .o_cap_addr(o_cap_addr), .o_cap_we(o_cap_we),
    .o_cap_valid(o_cap_valid)
  );

  // Reference model: every rule is evaluated by looking back over the
  // recorded bus history since the last reset.
  typedef struct {
    bit cyc, stb, we, ack, stall, err, clr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] sel;
  } smp_t;

  smp_t          h[$];
  int            st_h[$];
  int            out_h[$];
  logic [7:0]    exp_vec;
  int            exp_out, exp_st;
  bit            exp_cap_valid, exp_cap_we, last_we;
  logic [AW-1:0] exp_cap_addr, last_addr;

  function automatic void model_reset();
    h.delete(); st_h.delete(); out_h.delete();
    exp_vec = '0; exp_out = 0; exp_st = 0;
    exp_cap_valid = 0; exp_cap_we = 0; exp_cap_addr = '0;
    last_we = 0; last_addr = '0;
  endfunction

  task automatic bus_idle();
    bus_cyc = 0; bus_stb = 0; bus_we = 0; bus_addr = '0; bus_data = '0; bus_sel = '0;
    bus_ack = 0; bus_stall = 0; bus_err = 0; bus_clear = 0;
  endtask

  // Advance one clock; update the model from the inputs presented this cycle.
  task automatic tick();
    smp_t s, p;
    int k, prev_out, prev_st, nxt, acc, j, sd;
    bit prev_cyc, all_run, cur_req;
    logic [7:0] nf;
    s.cyc = bus_cyc; s.stb = bus_stb; s.we = bus_we; s.ack = bus_ack;
    s.stall = bus_stall; s.err = bus_err; s.clr = bus_clear;
    s.addr = bus_addr; s.data = bus_data; s.sel = bus_sel;
    h.push_back(s);
    k = h.size() - 1;
    prev_out = (k > 0) ? out_h[k-1] : 0;
    prev_st  = (k > 0) ? st_h[k-1] : 0;
    prev_cyc = (k > 0) && h[k-1].cyc;
    acc = 0;
    if (s.cyc) begin
      j = k;
      while (j >= 0 && h[j].cyc) begin
        acc += int'(h[j].stb && !h[j].stall);
        acc -= int'(h[j].ack || h[j].err);
        j--;
      end
    end
    acc = ((acc % (OMAX + 1)) + (OMAX + 1)) % (OMAX + 1);
    if (!s.cyc)             nxt = 0;
    else if (s.err)         nxt = 3;
    else if (prev_st == 0)  nxt = prev_cyc ? 0 : 1;
    else if (prev_st == 1)  nxt = (!s.stb && prev_out > 0) ? 2 : 1;
    else if (prev_st == 2)  nxt = s.stb ? 1 : 2;
    else                    nxt = 0;
    nf = '0;
    nf[0] = s.stb && !s.cyc;
    if (k > 0) begin
      p = h[k-1];
      nf[1] = p.cyc && p.stb && p.stall && s.cyc &&
              (!s.stb || s.we != p.we || s.addr != p.addr || s.data != p.data || s.sel != p.sel);
    end
    nf[2] = (s.ack || s.err) && !prev_cyc;
    nf[3] = s.ack && s.err;
    nf[4] = (s.ack && prev_out == 0) || (s.cyc && s.stb && !s.stall && prev_out == OMAX);
    if (k >= MAX_STALL - 1) begin
      all_run = 1;
      for (int m = k - MAX_STALL + 1; m <= k; m++) all_run &= h[m].stb && h[m].stall;
      nf[5] = all_run;
    end
    if (k >= MAX_ACK_DELAY - 1) begin
      all_run = 1;
      for (int m = k - MAX_ACK_DELAY + 1; m <= k; m++) begin
        sd = (m > 0) ? st_h[m-1] : 0;
        all_run &= (sd == 2) && !h[m].ack && !h[m].err;
      end
      nf[6] = all_run;
    end
    nf[7] = (k > 0 && h[k-1].err && s.cyc) || (OPT_RMW == 0 && s.cyc && !s.stb && prev_out == 0);
    exp_vec = s.clr ? nf : (exp_vec | nf);
    cur_req = s.cyc && s.stb;
    if (nf != 0 && (!exp_cap_valid || s.clr)) begin
      exp_cap_valid = 1;
      exp_cap_addr  = cur_req ? s.addr : last_addr;
      exp_cap_we    = cur_req ? s.we : last_we;
    end else if (s.clr) begin
      exp_cap_valid = 0; exp_cap_addr = '0; exp_cap_we = 0;
    end
    if (cur_req) begin last_addr = s.addr; last_we = s.we; end
    st_h.push_back(nxt); out_h.push_back(acc);
    exp_st = nxt; exp_out = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o_fault_vec !== 8'h00 || o_fault !== 1'b0) begin
      bad++; $display("FAIL reset_fault got=%h/%b want=00/0", o_fault_vec, o_fault);
    end
    total++;
    if (o_outstanding !== '0 || o_state !== 2'd0) begin
      bad++; $display("FAIL reset_state got out=%0d st=%0d want 0/0", o_outstanding, o_state);
    end
    total++;
    if (o_cap_valid !== 1'b0 || o_cap_addr !== '0 || o_cap_we !== 1'b0) begin
      bad++; $display("FAIL reset_cap got v=%b a=%h we=%b want zeros", o_cap_valid, o_cap_addr, o_cap_we);
    end
    rst_n = 1;
    model_reset();
    tick();
    total++;
    if (o_fault_vec !== 8'h00 || o_state !== 2'd0) begin
      bad++; $display("FAIL reset_idle got vec=%h st=%0d want 00/0", o_fault_vec, o_state);
    end
  endtask

  task automatic test_reads();
    bit cyc_t[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit stb_t[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    bit ack_t[8]  = '{0, 0, 0, 0, 1, 1, 1, 0};
    int out_t[8]  = '{1, 2, 3, 3, 2, 1, 0, 0};
    int st_t[8]   = '{1, 1, 1, 2, 2, 2, 2, 0};
    bus_idle();
    for (int i = 0; i < 8; i++) begin
      bus_cyc = cyc_t[i]; bus_stb = stb_t[i]; bus_ack = ack_t[i];
      bus_addr = 32'h100 + 32'(4 * i); bus_sel = 4'hF;
      tick();
      total++;
      if (o_outstanding !== out_t[i][LGDEPTH-1:0]) begin
        bad++; $display("FAIL reads_outstanding c%0d got=%0d want=%0d", i, o_outstanding, out_t[i]);
      end
      total++;
      if (o_state !== st_t[i][1:0]) begin
        bad++; $display("FAIL reads_state c%0d got=%0d want=%0d", i, o_state, st_t[i]);
      end
      total++;
      if (o_fault !== 1'b0) begin
        bad++; $display("FAIL reads_fault c%0d got=%b vec=%h want=0", i, o_fault, o_fault_vec);
      end
    end
  endtask

  task automatic test_stall_limit();
    logic [7:0] want;
    bus_idle();
    bus_cyc = 1; bus_stb = 1; bus_stall = 1; bus_addr = 32'h200; bus_sel = 4'hF;
    for (int i = 0; i < MAX_STALL; i++) begin
      tick();
      want = (i == MAX_STALL - 1) ? 8'h20 : 8'h00;
      total++;
      if (o_fault_vec !== want) begin
        bad++; $display("FAIL stall_limit c%0d got=%h want=%h", i, o_fault_vec, want);
      end
    end
    bus_idle();
    tick();
    total++;
    if (o_fault_vec !== 8'h20) begin
      bad++; $display("FAIL stall_sticky got=%h want=20", o_fault_vec);
    end
    bus_clear = 1;
    tick();
    bus_clear = 0;
    total++;
    if (o_fault_vec !== 8'h00) begin
      bad++; $display("FAIL stall_clear got=%h want=00", o_fault_vec);
    end
  endtask

  task automatic test_ack_unexpected();
    bus_idle();
    bus_cyc = 1; bus_stb = 1; bus_stall = 1; bus_addr = 32'h300;
    tick();
    bus_ack = 1;
    tick();
    total++;
    if (o_fault_vec !== 8'h10) begin
      bad++; $display("FAIL ack_no_outstanding got=%h want=10", o_fault_vec);
    end
    bus_idle();
    tick();
    bus_clear = 1;
    tick();
    bus_clear = 0;
    total++;
    if (o_fault_vec !== 8'h00 || o_fault !== 1'b0) begin
      bad++; $display("FAIL ack_clear got=%h/%b want=00/0", o_fault_vec, o_fault);
    end
  endtask

  task automatic test_clear_priority();
    bus_idle();
    tick();
    bus_ack = 1;
    tick();
    total++;
    if (o_fault_vec !== 8'h14) begin
      bad++; $display("FAIL resp_no_cyc got=%h want=14", o_fault_vec);
    end
    bus_ack = 0; bus_stb = 1; bus_clear = 1;
    tick();
    total++;
    if (o_fault_vec !== 8'h01) begin
      bad++; $display("FAIL clear_vs_new got=%h want=01", o_fault_vec);
    end
    bus_stb = 0;
    tick();
    bus_clear = 0;
    total++;
    if (o_fault_vec !== 8'h00) begin
      bad++; $display("FAIL clear_only got=%h want=00", o_fault_vec);
    end
  endtask

  task automatic test_err_hold();
    bus_idle();
    bus_cyc = 1; bus_stb = 1; bus_addr = 32'h1000; bus_sel = 4'hF;
    tick();
    total++;
    if (o_state !== 2'd1 || o_outstanding !== 4'd1) begin
      bad++; $display("FAIL err_req got st=%0d out=%0d want 1/1", o_state, o_outstanding);
    end
    bus_stb = 0; bus_err = 1;
    tick();
    total++;
    if (o_state !== 2'd3 || o_fault_vec !== 8'h00) begin
      bad++; $display("FAIL err_abort got st=%0d vec=%h want 3/00", o_state, o_fault_vec);
    end
    bus_err = 0;
    tick();
    total++;
    if (o_fault_vec !== 8'h80 || o_fault !== 1'b1) begin
      bad++; $display("FAIL err_cyc_hold got=%h/%b want=80/1", o_fault_vec, o_fault);
    end
`ifdef WBMON_CAPTURE_EN
    total++;
    if (o_cap_valid !== 1'b1 || o_cap_addr !== 32'h1000 || o_cap_we !== 1'b0) begin
      bad++; $display("FAIL err_capture got v=%b a=%h we=%b want 1/1000/0", o_cap_valid, o_cap_addr, o_cap_we);
    end
`else
    total++;
    if (o_cap_valid !== 1'b0 || o_cap_addr !== '0) begin
      bad++; $display("FAIL err_capture_off got v=%b a=%h want 0/0", o_cap_valid, o_cap_addr);
    end
`endif
    bus_idle();
    tick();
    bus_clear = 1;
    tick();
    bus_clear = 0;
    total++;
    if (o_fault_vec !== 8'h00 || o_cap_valid !== 1'b0) begin
      bad++; $display("FAIL err_clear got vec=%h v=%b want 00/0", o_fault_vec, o_cap_valid);
    end
  endtask

  task automatic test_stall_change_reset();
    bus_idle();
    bus_cyc = 1; bus_stb = 1; bus_stall = 1; bus_addr = 32'h40; bus_sel = 4'hF;
    tick();
    total++;
    if (o_fault_vec !== 8'h00) begin
      bad++; $display("FAIL stall_hold got=%h want=00", o_fault_vec);
    end
    bus_stall = 0; bus_addr = 32'h44;
    tick();
    total++;
    if (o_fault_vec !== 8'h02) begin
      bad++; $display("FAIL stall_change got=%h want=02", o_fault_vec);
    end
    bus_stall = 1; bus_addr = 32'h48;
    tick();
    #2;
    rst_n = 0;
    #1;
    total++;
    if (o_fault_vec !== 8'h00 || o_fault !== 1'b0 || o_outstanding !== '0 || o_state !== 2'd0) begin
      bad++; $display("FAIL midreset got vec=%h f=%b out=%0d st=%0d want zeros", o_fault_vec, o_fault, o_outstanding, o_state);
    end
    total++;
    if (o_cap_valid !== 1'b0 || o_cap_addr !== '0 || o_cap_we !== 1'b0) begin
      bad++; $display("FAIL midreset_cap got v=%b a=%h we=%b want zeros", o_cap_valid, o_cap_addr, o_cap_we);
    end
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    tick();
    total++;
    if (o_fault_vec !== 8'h00 || o_state !== 2'd0 || o_outstanding !== '0) begin
      bad++; $display("FAIL after_reset got vec=%h st=%0d out=%0d want 00/0/0", o_fault_vec, o_state, o_outstanding);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 8))
          0: bus_cyc   = ~bus_cyc;
          1: bus_stb   = ~bus_stb;
          2: bus_we    = ~bus_we;
          3: bus_addr  = 32'h40 << $urandom_range(0, 2);
          4: bus_data  = 32'($urandom_range(0, 3));
          5: bus_sel   = 4'($urandom_range(0, 15));
          6: bus_ack   = ~bus_ack;
          7: bus_stall = ~bus_stall;
          default: bus_err = ~bus_err;
        endcase
      end
      bus_clear = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (o_fault_vec !== exp_vec) begin
        bad++; $display("FAIL rand_vec n=%0d got=%h want=%h", n, o_fault_vec, exp_vec);
      end
      total++;
      if (o_fault !== (exp_vec != 0)) begin
        bad++; $display("FAIL rand_fault n=%0d got=%b want=%b", n, o_fault, exp_vec != 0);
      end
      total++;
      if (o_outstanding !== exp_out[LGDEPTH-1:0]) begin
        bad++; $display("FAIL rand_outstanding n=%0d got=%0d want=%0d", n, o_outstanding, exp_out);
      end
      total++;
      if (o_state !== exp_st[1:0]) begin
        bad++; $display("FAIL rand_state n=%0d got=%0d want=%0d", n, o_state, exp_st);
      end
`ifdef WBMON_CAPTURE_EN
      total++;
      if (o_cap_valid !== exp_cap_valid || o_cap_addr !== exp_cap_addr || o_cap_we !== exp_cap_we) begin
        bad++; $display("FAIL rand_cap n=%0d got v=%b a=%h we=%b want v=%b a=%h we=%b",
                        n, o_cap_valid, o_cap_addr, o_cap_we, exp_cap_valid, exp_cap_addr, exp_cap_we);
      end
`else
      total++;
      if (o_cap_valid !== 1'b0 || o_cap_addr !== '0 || o_cap_we !== 1'b0) begin
        bad++; $display("FAIL rand_cap_off n=%0d got v=%b a=%h we=%b want zeros", n, o_cap_valid, o_cap_addr, o_cap_we);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reads();
    test_stall_limit();
    test_ack_unexpected();
    test_clear_priority();
    test_err_hold();
    test_stall_change_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_protocol_monitor.md
WB_PROTOCOL_MONITOR -- requirements
Module: wb_protocol_monitor

Interface
REQ-001 SHALL have parameter AW, default 32: Wishbone address width.
REQ-002 SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-003 SHALL have parameter LGDEPTH, default 4: width of the request, ack and outstanding counters.
REQ-004 SHALL have parameter MAX_STALL, default 4: stall-cycle limit; 0 disables the check.
REQ-005 SHALL have parameter MAX_ACK_DELAY, default 10: ack-wait limit; 0 disables the check.
REQ-006 SHALL have parameter OPT_RMW, default 0: 1 permits CYC held with nothing outstanding.
REQ-007 SHALL have ports i_clk (in, 1, clock) and i_reset_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-008 SHALL have inputs i_wb_cyc, i_wb_stb, i_wb_we (1 each), i_wb_addr (AW), i_wb_data (DW), i_wb_sel (DW/8), i_wb_ack, i_wb_stall, i_wb_err (1 each): passively tapped bus.
REQ-009 SHALL have input i_clear (1): synchronous clear of sticky fault state.
REQ-010 SHALL have outputs o_fault (1, OR of vector), o_fault_vec (8, sticky per-rule flags), o_outstanding (LGDEPTH), o_state (2).
REQ-011 SHALL have outputs o_cap_addr (AW), o_cap_we (1), o_cap_valid (1): first-fault capture.

Function
REQ-012 SHALL never drive the bus; all inputs are observation only.
REQ-013 SHALL count accepted requests (stb&&!stall) and responses (ack||err); both counters zero whenever CYC is low; o_outstanding = reqs-acks, registered, 0 when CYC low.
REQ-014 SHALL run FSM IDLE(0) -> BUSY(1) on CYC rise; BUSY -> WAIT(2) when STB low with outstanding>0; WAIT -> BUSY on STB; any -> ABORT(3) on ERR; ABORT -> IDLE next cycle; any -> IDLE when CYC low.
REQ-015 SHALL set bit0 on STB without CYC.
REQ-016 SHALL set bit1 when a stalled request, CYC still high, drops STB or changes we/addr/data/sel next cycle.
REQ-017 SHALL set bit2 on ACK or ERR one cycle after CYC was low.
REQ-018 SHALL set bit3 on ACK and ERR in the same cycle.
REQ-019 SHALL set bit4 on ACK with outstanding 0, or on an accepted request when outstanding equals 2^LGDEPTH-1.
REQ-020 SHALL set bit5 when STB&&STALL persists MAX_STALL consecutive cycles.
REQ-021 SHALL set bit6 when WAIT persists MAX_ACK_DELAY cycles without ACK/ERR.
REQ-022 SHALL set bit7 when CYC remains high the cycle after ERR, or (OPT_RMW=0) CYC high, STB low, outstanding 0.
REQ-023 SHALL set fault bits one cycle after the offending bus cycle; bits stay set until i_clear.
REQ-024 SHALL give a newly detected fault priority over i_clear in the same cycle.
REQ-025 SHALL saturate stall and ack-wait counters at their limit; reset them on the qualifying condition ending.

Reset
REQ-026 SHALL on i_reset_n low asynchronously zero all counters, o_fault, o_fault_vec, o_outstanding, capture outputs, and set o_state to IDLE.
REQ-027 SHALL treat reset mid-transaction as abandoning it; no fault for the aborted cycle.

Configuration
REQ-028 SHALL with WBMON_CAPTURE_EN defined latch addr/we of the current or last request on the first fault after reset/clear and set o_cap_valid; without it tie o_cap_addr, o_cap_we, o_cap_valid to 0.

Structure
REQ-029 SHALL place fault-bit index constants, FAULT_W=8 and state encodings in shared package wb_mon_pkg.
REQ-030 SHALL implement the stall/ack-wait saturating counter as sub-module wb_mon_timer, instantiated twice.

Verification
REQ-031 SHALL verify: 3 reads, no stall, acks 2 cycles later -> o_fault=0, o_outstanding 3->0, states IDLE,BUSY,WAIT,IDLE.
REQ-032 SHALL verify: MAX_STALL=4, STB&&STALL held 4 cycles -> o_fault_vec=8'h20 next cycle.
REQ-033 SHALL verify: ACK with outstanding 0 -> 8'h10; then i_clear -> 8'h00.
REQ-034 SHALL verify: ERR on request addr 0x1000, CYC held next cycle -> bit7 set; with WBMON_CAPTURE_EN, o_cap_addr=0x1000.
REQ-035 SHALL verify: stalled request changes addr 0x40->0x44 -> 8'h02; i_reset_n low mid-cycle -> all outputs zero, IDLE.
